// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. The master side issues
// operands and start; the slave side (the subtractor) returns status and result.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bi,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, diff, bout
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow-out bo.
module full_sub
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out, purely combinational.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule : full_sub

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_sub cell processes one bit per clock,
// LSB first. Operands are captured on an accepted start, the result is
// published to diff/bout on the cycle the FSM enters DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] d_sr_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             brw_reg;
  logic             bout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;
  logic [WIDTH-1:0] d_sr_next;

  full_sub u_cell (
    .a  (a_sr_reg[0]),
    .b  (b_sr_reg[0]),
    .bi (brw_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // The difference bit of the current cycle enters at the MSB, so after
  // WIDTH shifts the first (LSB) bit sits at position 0.
  assign d_sr_next = {cell_d, d_sr_reg[WIDTH-1:1]};
  assign last_bit  = (cnt_reg == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and the serial datapath (shift registers, borrow, count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg <= '0;
      b_sr_reg <= '0;
      d_sr_reg <= '0;
      brw_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sr_reg <= bus.a;
            b_sr_reg <= bus.b;
            brw_reg  <= bus.bi;
            d_sr_reg <= '0;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sr_reg <= a_sr_reg >> 1;
          b_sr_reg <= b_sr_reg >> 1;
          brw_reg  <= cell_bo;
          d_sr_reg <= d_sr_next;
          cnt_reg  <= cnt_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded with the final bit's values on the edge that
  // enters DONE, so diff/bout are valid in the same cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg <= '0;
      bout_reg <= 1'b0;
    end else if (state_reg == RUN && last_bit) begin
      diff_reg <= d_sr_next;
      bout_reg <= cell_bo;
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): latency, result vectors,
// back-to-back ops, ignored start, mid-operation reset, exhaustive sweep.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then drop start.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv);
    bus.a     = av;
    bus.b     = bv;
    bus.bi    = biv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Advance until done is seen, bounded; cyc reports ticks taken.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.diff !== 4'd0) begin n_bad++; $display("FAIL reset_diff got=%0d want=0", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout got=%b want=0", bus.bout); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  // 9-3: busy for 5 cycles, done only in the 5th, diff stays 0 until then.
  task automatic test_latency();
    launch(4'd9, 4'd3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy cyc=%0d got=%b want=1", k, bus.busy); end
      n_cmp++; if (bus.done !== (k == 5)) begin n_bad++; $display("FAIL lat_done cyc=%0d got=%b want=%b", k, bus.done, (k == 5)); end
      if (k < 5) begin
        n_cmp++; if (bus.diff !== 4'd0) begin n_bad++; $display("FAIL lat_diff_hold cyc=%0d got=%0d want=0", k, bus.diff); end
        tick();
      end
    end
    n_cmp++; if (bus.diff !== 4'd6) begin n_bad++; $display("FAIL lat_diff got=%0d want=6", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL lat_bout got=%b want=0", bus.bout); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL lat_idle busy=%b done=%b want=0/0", bus.busy, bus.done); end
    n_cmp++; if (bus.diff !== 4'd6) begin n_bad++; $display("FAIL lat_diff_after got=%0d want=6", bus.diff); end
    $display("test_latency 9-3-0 -> diff=%0d bout=%b", bus.diff, bus.bout);
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{4'd3, 4'd0, 4'd15};
    logic [W-1:0] vb [3] = '{4'd9, 4'd0, 4'd15};
    logic         vi [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] ed [3] = '{4'd10, 4'd15, 4'd15};
    logic         eb [3] = '{1'b1, 1'b1, 1'b1};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vi[i]);
      wait_done(cyc);
      n_cmp++; if (cyc != W) begin n_bad++; $display("FAIL vec_latency i=%0d got=%0d want=%0d", i, cyc, W); end
      n_cmp++; if (bus.diff !== ed[i]) begin n_bad++; $display("FAIL vec_diff i=%0d got=%0d want=%0d", i, bus.diff, ed[i]); end
      n_cmp++; if (bus.bout !== eb[i]) begin n_bad++; $display("FAIL vec_bout i=%0d got=%b want=%b", i, bus.bout, eb[i]); end
      $display("test_vectors a=%0d b=%0d bi=%b -> diff=%0d bout=%b", va[i], vb[i], vi[i], bus.diff, bus.bout);
      tick();
    end
  endtask

  // start held high: done every 6 cycles, diff=3 on each pulse.
  task automatic test_back_to_back();
    int pulses = 0;
    bus.a = 4'd5; bus.b = 4'd2; bus.bi = 1'b0; bus.start = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 18) bus.start = 1'b0;
      n_cmp++; if (bus.done !== (t % 6 == 5)) begin n_bad++; $display("FAIL b2b_done t=%0d got=%b want=%b", t, bus.done, (t % 6 == 5)); end
      if (bus.done === 1'b1) begin
        pulses++;
        n_cmp++; if (bus.diff !== 4'd3) begin n_bad++; $display("FAIL b2b_diff t=%0d got=%0d want=3", t, bus.diff); end
      end
    end
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
    tick();
    $display("test_back_to_back pulses=%0d", pulses);
  endtask

  // New operands and start during RUN/DONE must not disturb the op.
  task automatic test_ignore_start();
    int cyc;
    launch(4'd12, 4'd5, 1'b0);
    tick();
    bus.a = 4'd1; bus.b = 4'd1; bus.bi = 1'b1; bus.start = 1'b1;
    wait_done(cyc);
    bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ign_timeout got=%b want=1", bus.done); end
    n_cmp++; if (bus.diff !== 4'd7) begin n_bad++; $display("FAIL ign_diff got=%0d want=7", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL ign_bout got=%b want=0", bus.bout); end
    tick(); tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_no_restart busy=%b want=0", bus.busy); end
    n_cmp++; if (bus.diff !== 4'd7) begin n_bad++; $display("FAIL ign_diff_hold got=%0d want=7", bus.diff); end
    $display("test_ignore_start 12-5 -> diff=%0d", bus.diff);
  endtask

  task automatic test_reset_midop();
    int cyc;
    int seen = 0;
    launch(4'd9, 4'd3, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.diff !== 4'd0) begin n_bad++; $display("FAIL rst_mid_diff got=%0d want=0", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL rst_mid_bout got=%b want=0", bus.bout); end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_activity got=%0d want=0", seen); end
    launch(4'd7, 4'd1, 1'b0);
    wait_done(cyc);
    n_cmp++; if (bus.done !== 1'b1 || bus.diff !== 4'd6 || bus.bout !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_next done=%b diff=%0d bout=%b want=1/6/0", bus.done, bus.diff, bus.bout);
    end
    tick();
    $display("test_reset_midop next 7-1 -> diff=%0d", bus.diff);
  endtask

  task automatic test_exhaustive();
    int cyc;
    int bad0 = n_bad;
    logic [W:0] expv;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bj = 0; bj < 16; bj++) begin
        for (int ci = 0; ci < 2; ci++) begin
          expv = {1'b0, W'(ai)} - {1'b0, W'(bj)} - (W+1)'(ci);
          launch(W'(ai), W'(bj), ci[0]);
          wait_done(cyc);
          n_cmp++;
          if (bus.done !== 1'b1 || {bus.bout, bus.diff} !== expv) begin
            n_bad++;
            $display("FAIL exh a=%0d b=%0d bi=%0d got done=%b bout=%b diff=%0d want bout=%b diff=%0d",
                     ai, bj, ci, bus.done, bus.bout, bus.diff, expv[W], expv[W-1:0]);
          end
          tick();
        end
      end
    end
    $display("test_exhaustive 512 ops, %0d bad", n_bad - bad0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_subtractor
